// File: rtl/universal_dreg.sv
// universal_dreg -- universal shift/load register with shift counter.
//
// Operation (sampled on rising clk, only while E=1):
//   mode 00 hold, 01 shift right (sin_r enters MSB, LSB -> sout),
//   10 shift left (sin_l enters LSB, MSB -> sout), 11 parallel load of D.
// E=0 holds all state regardless of mode.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   E, mode        enable and 2-bit operation select
//   D              parallel load data
//   sin_r, sin_l   serial inputs for right / left shift
//   Q, Qbar        register contents and its combinational complement
//   sout           registered bit most recently shifted out
//   cnt            shifts since last load, saturating at WIDTH
//   done           one-cycle pulse on the shift that brings cnt to WIDTH
//   par            (only with UNIVERSAL_DREG_PARITY_EN) XOR of all Q bits
//
// Parameters: WIDTH 2..32, CW must satisfy 2**CW > WIDTH.
// Optional feature macro: UNIVERSAL_DREG_PARITY_EN.
module universal_dreg #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             sout,
  output logic [CW-1:0]    cnt,
`ifdef UNIVERSAL_DREG_PARITY_EN
  output logic             par,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_SHR  = 2'b01,
    M_SHL  = 2'b10,
    M_LOAD = 2'b11
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             done_nxt;
  logic             shift;

  assign shift = E && ((mode == M_SHR) || (mode == M_SHL));

  always_comb begin
    q_nxt    = Q;
    sout_nxt = sout;
    cnt_nxt  = cnt;
    done_nxt = 1'b0;   // done is a pulse: cleared by anything but the saturating shift
    if (E) begin
      case (mode_e'(mode))
        M_SHR: begin
          q_nxt    = {sin_r, Q[WIDTH-1:1]};
          sout_nxt = Q[0];
        end
        M_SHL: begin
          q_nxt    = {Q[WIDTH-2:0], sin_l};
          sout_nxt = Q[WIDTH-1];
        end
        M_LOAD: begin
          q_nxt   = D;
          cnt_nxt = '0;
        end
        default: ;
      endcase
    end
    // Counter saturates at WIDTH; done fires only on the WIDTH-1 -> WIDTH step,
    // so further shifts at saturation do not re-trigger it.
    if (shift && (cnt != CNT_MAX)) begin
      cnt_nxt  = cnt + 1'b1;
      done_nxt = (cnt == CNT_MAX - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q    <= '0;
      sout <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      Q    <= q_nxt;
      sout <= sout_nxt;
      cnt  <= cnt_nxt;
      done <= done_nxt;
    end
  end

  // Purely combinational from Q so the complement holds through reset too.
  assign Qbar = ~Q;

`ifdef UNIVERSAL_DREG_PARITY_EN
  assign par = ^Q;
`endif

endmodule

// File: tb/tb_universal_dreg.sv
// Directed self-checking bench for universal_dreg (WIDTH=8, CW=4).
module tb_universal_dreg;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             E;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic             sin_r, sin_l;
  logic [WIDTH-1:0] Q, Qbar;
  logic             sout;
  logic [CW-1:0]    cnt;
  logic             done;
`ifdef UNIVERSAL_DREG_PARITY_EN
  logic             par;
`endif

  int checks   = 0;
  int failures = 0;

  universal_dreg #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .E(E), .mode(mode), .D(D),
    .sin_r(sin_r), .sin_l(sin_l), .Q(Q), .Qbar(Qbar), .sout(sout),
    .cnt(cnt),
`ifdef UNIVERSAL_DREG_PARITY_EN
    .par(par),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] val);
    E = 1'b1; mode = 2'b11; D = val;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; E = 1'b0; mode = 2'b00; D = '0; sin_r = 1'b0; sin_l = 1'b0;
    #3;
    checks++;
    if (Q !== 8'h00 || Qbar !== 8'hFF || sout !== 1'b0 || cnt !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state Q=%h Qbar=%h sout=%b cnt=%0d done=%b, want Q=00 Qbar=FF sout=0 cnt=0 done=0",
               Q, Qbar, sout, cnt, done);
    end
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    do_load(8'hA5);
    checks++;
    if (Q !== 8'hA5 || Qbar !== 8'h5A || cnt !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL load_a5 Q=%h Qbar=%h cnt=%0d done=%b, want A5 5A 0 0", Q, Qbar, cnt, done);
    end
    // E=1 mode 00 must hold
    mode = 2'b00; D = 8'h3C;
    step();
    checks++;
    if (Q !== 8'hA5 || cnt !== 4'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mode00_hold Q=%h cnt=%0d done=%b, want A5 0 0", Q, cnt, done);
    end
  endtask

  task automatic test_shift_right();
    logic exp_sout [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_load(8'hA5);
    mode = 2'b01; sin_r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (sout !== exp_sout[i] || cnt !== 4'(i + 1) || done !== (i == 7)) begin
        failures++;
        $display("FAIL shr_step%0d sout=%b cnt=%0d done=%b, want %b %0d %b",
                 i, sout, cnt, done, exp_sout[i], i + 1, (i == 7));
      end
    end
    checks++;
    if (Q !== 8'h00 || Qbar !== 8'hFF) begin
      failures++;
      $display("FAIL shr_final Q=%h Qbar=%h, want 00 FF", Q, Qbar);
    end
    E = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || cnt !== 4'd8) begin
      failures++;
      $display("FAIL shr_done_pulse done=%b cnt=%0d, want 0 8", done, cnt);
    end
  endtask

  task automatic test_shift_left_hold();
    do_load(8'h81);
    mode = 2'b10; sin_l = 1'b1;
    step();
    checks++;
    if (Q !== 8'h03 || sout !== 1'b1 || cnt !== 4'd1) begin
      failures++;
      $display("FAIL shl_step0 Q=%h sout=%b cnt=%0d, want 03 1 1", Q, sout, cnt);
    end
    step(); step();
    checks++;
    if (Q !== 8'h0F || sout !== 1'b0 || cnt !== 4'd3 || done !== 1'b0) begin
      failures++;
      $display("FAIL shl_3 Q=%h sout=%b cnt=%0d done=%b, want 0F 0 3 0", Q, sout, cnt, done);
    end
    // E=0 must dominate even a load request
    E = 1'b0; mode = 2'b11; D = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (Q !== 8'h0F || Qbar !== 8'hF0 || sout !== 1'b0 || cnt !== 4'd3 || done !== 1'b0) begin
        failures++;
        $display("FAIL hold_e0_%0d Q=%h Qbar=%h sout=%b cnt=%0d done=%b, want 0F F0 0 3 0",
                 i, Q, Qbar, sout, cnt, done);
      end
    end
  endtask

  task automatic test_saturate();
    int done_cnt = 0;
    int exp_cnt;
    do_load(8'h5A);
    sin_r = 1'b0; sin_l = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mode = (i % 2 == 0) ? 2'b01 : 2'b10;  // mixed directions all count
      step();
      exp_cnt = (i + 1 > 8) ? 8 : i + 1;
      if (done === 1'b1) done_cnt++;
      checks++;
      if (cnt !== 4'(exp_cnt) || done !== (i == 7)) begin
        failures++;
        $display("FAIL sat_step%0d cnt=%0d done=%b, want %0d %b", i, cnt, done, exp_cnt, (i == 7));
      end
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL sat_done_count got=%0d want=1", done_cnt);
    end
    do_load(8'h11);
    checks++;
    if (cnt !== 4'd0 || done !== 1'b0 || Q !== 8'h11) begin
      failures++;
      $display("FAIL sat_reload cnt=%0d done=%b Q=%h, want 0 0 11", cnt, done, Q);
    end
  endtask

  task automatic test_async_reset();
    do_load(8'hFF);
    mode = 2'b01; sin_r = 1'b0;
    repeat (4) step();
    checks++;
    if (Q !== 8'h0F || cnt !== 4'd4 || sout !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset Q=%h cnt=%0d sout=%b, want 0F 4 1", Q, cnt, sout);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Q !== 8'h00 || Qbar !== 8'hFF || cnt !== 4'd0 || sout !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset Q=%h Qbar=%h cnt=%0d sout=%b done=%b, want 00 FF 0 0 0",
               Q, Qbar, cnt, sout, done);
    end
    step();
    rst_n = 1'b1;
    sin_r = 1'b1;
    step();
    checks++;
    if (cnt !== 4'd1 || Q !== 8'h80 || sout !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_shift cnt=%0d Q=%h sout=%b, want 1 80 0", cnt, Q, sout);
    end
  endtask

`ifdef UNIVERSAL_DREG_PARITY_EN
  task automatic test_parity();
    do_load(8'h07);
    checks++;
    if (par !== 1'b1) begin
      failures++;
      $display("FAIL parity_07 par=%b want 1", par);
    end
    do_load(8'h03);
    checks++;
    if (par !== 1'b0) begin
      failures++;
      $display("FAIL parity_03 par=%b want 0", par);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_shift_right();
    test_shift_left_hold();
    test_saturate();
    test_async_reset();
`ifdef UNIVERSAL_DREG_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
